arf_sequencer: RTL

ARF_SEQUENCER -- requirements
Module: arf_sequencer

---
 rtl/arf_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/arf_sequencer.sv
// Micro-op sequencer for the address register file (PC/SP/AR): turns one requested
// operation into a short sequence of register, memory and IR control strobes.
module arf_sequencer #(
  parameter int unsigned FETCH_WORDS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [2:0] op,
  output logic [2:0] reg_sel,
  output logic [1:0] fun_sel,
  output logic [1:0] out_c_sel,
  output logic [1:0] out_d_sel,
  output logic       arf_i_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] ir_load,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    StIdle, StF1, StF2, StPushDec, StPushWr, StPopRd, StPopInc, StJmpLd,
    StCallDec, StCallWr, StCallLd, StRetRd, StClr, StErr
  } state_e;

  typedef struct packed {
    logic [2:0] reg_sel;
    logic [1:0] fun_sel;
    logic [1:0] out_c_sel;
    logic [1:0] out_d_sel;
    logic       arf_i_sel;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] ir_load;
    logic       busy;
    logic       done;
    logic       err;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != StIdle);
    case (s)
      StF1: begin
        c.mem_read = 1'b1; c.ir_load = 2'b01; c.reg_sel = 3'b001; c.fun_sel = 2'b01;
        c.done     = (FETCH_WORDS == 1);
      end
      StF2: begin
        c.mem_read = 1'b1; c.ir_load = 2'b10; c.reg_sel = 3'b001; c.fun_sel = 2'b01;
        c.done     = 1'b1;
      end
      StPushDec: begin c.reg_sel = 3'b010; c.fun_sel = 2'b00; end
      StPushWr: begin
        c.out_d_sel = 2'b01; c.out_c_sel = 2'b10; c.mem_write = 1'b1; c.done = 1'b1;
      end
      StPopRd: begin
        c.out_d_sel = 2'b01; c.mem_read = 1'b1; c.arf_i_sel = 1'b1;
        c.reg_sel   = 3'b100; c.fun_sel = 2'b10;
      end
      // Shared by POP and RET: SP post-increment closes both ops.
      StPopInc: begin c.reg_sel = 3'b010; c.fun_sel = 2'b01; c.done = 1'b1; end
      StJmpLd:  begin c.reg_sel = 3'b001; c.fun_sel = 2'b10; c.done = 1'b1; end
      StCallDec: begin c.reg_sel = 3'b010; c.fun_sel = 2'b00; end
      StCallWr: begin c.out_d_sel = 2'b01; c.out_c_sel = 2'b00; c.mem_write = 1'b1; end
      StCallLd: begin c.reg_sel = 3'b001; c.fun_sel = 2'b10; c.done = 1'b1; end
      StRetRd: begin
        c.out_d_sel = 2'b01; c.mem_read = 1'b1; c.arf_i_sel = 1'b1;
        c.reg_sel   = 3'b001; c.fun_sel = 2'b10;
      end
      StClr: begin c.reg_sel = 3'b111; c.fun_sel = 2'b11; c.done = 1'b1; end
      StErr: begin c.done = 1'b1; c.err = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: begin
        if (req) begin
          case (op)
            3'b000:  state_d = StF1;
            3'b001:  state_d = StPushDec;
            3'b010:  state_d = StPopRd;
            3'b011:  state_d = StJmpLd;
            3'b100:  state_d = StCallDec;
            3'b101:  state_d = StRetRd;
            3'b110:  state_d = StClr;
            default: state_d = StErr;
          endcase
        end
      end
      StF1:      state_d = (FETCH_WORDS == 2) ? StF2 : StIdle;
      StPushDec: state_d = StPushWr;
      StPopRd:   state_d = StPopInc;
      StCallDec: state_d = StCallWr;
      StCallWr:  state_d = StCallLd;
      StRetRd:   state_d = StPopInc;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign reg_sel   = ctrl_q.reg_sel;
  assign fun_sel   = ctrl_q.fun_sel;
  assign out_c_sel = ctrl_q.out_c_sel;
  assign out_d_sel = ctrl_q.out_d_sel;
  assign arf_i_sel = ctrl_q.arf_i_sel;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign ir_load   = ctrl_q.ir_load;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign err       = ctrl_q.err;

endmodule
